// File: rtl/seg_display_arbiter_if.sv
// Request/data/display bundle between the two sources and the
// 7-segment display arbiter.
interface seg_display_arbiter_if;
  logic [1:0] req;
  logic [1:0] blink;
  logic [3:0] src0_hex1;
  logic [3:0] src0_hex0;
  logic [3:0] src1_hex1;
  logic [3:0] src1_hex0;
  logic [1:0] grant;
  logic       en7Seg;
  logic [3:0] hex1;
  logic [3:0] hex0;

  modport master (
    output req, blink,
    output src0_hex1, src0_hex0,
    output src1_hex1, src1_hex0,
    input  grant, en7Seg, hex1, hex0
  );

  modport slave (
    input  req, blink,
    input  src0_hex1, src0_hex0,
    input  src1_hex1, src1_hex0,
    output grant, en7Seg, hex1, hex0
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the 2-digit hex display driver with a
// minimum hold time and per-source blink gating of the enable.
module seg_display_arbiter #(
  parameter int CLK_PER_TICK = 50000,
  parameter int MIN_HOLD     = 500,
  parameter int BLINK_TICKS  = 250
) (
  input  logic clk,
  input  logic rst,
  seg_display_arbiter_if.slave bus
);

  localparam int PW = $clog2(CLK_PER_TICK);
  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_PER_TICK - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);
  localparam logic [BW-1:0] BLK_MAX  = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic          ptr_q, ptr_d;
  logic [1:0]    grant_q, grant_d;
  logic          en_q, en_d;
  logic [3:0]    hex1_q, hex1_d;
  logic [3:0]    hex0_q, hex0_d;

  logic tick;
  logic owned;
  logic expired;
  logic enter;
  logic own_d;

  assign tick    = (pre_q == PRE_MAX);
  assign owned   = (state_q != IDLE);
  assign expired = (hold_q == HOLD_MAX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req == 2'b11)
          state_d = ptr_q ? OWN0 : OWN1;
        else if (bus.req[0])
          state_d = OWN0;
        else if (bus.req[1])
          state_d = OWN1;
      end
      OWN0: begin
        if (!bus.req[0])
          state_d = bus.req[1] ? OWN1 : IDLE;
        else if (expired && bus.req[1])
          state_d = OWN1;
      end
      OWN1: begin
        if (!bus.req[1])
          state_d = bus.req[0] ? OWN0 : IDLE;
        else if (expired && bus.req[0])
          state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter = (state_d != IDLE) && (state_d != state_q);
  assign own_d = (state_d == OWN1);

  // a switch on a tick edge restarts the new owner's counters
  always_comb begin
    pre_d   = tick ? '0 : pre_q + 1'b1;
    hold_d  = hold_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    ptr_d   = ptr_q;
    if (enter) begin
      hold_d  = '0;
      bcnt_d  = '0;
      phase_d = 1'b1;
      ptr_d   = own_d;
    end else if (owned && tick) begin
      if (!expired)
        hold_d = hold_q + 1'b1;
      if (bcnt_q == BLK_MAX) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    grant_d = 2'b00;
    en_d    = 1'b0;
    hex1_d  = hex1_q;
    hex0_d  = hex0_q;
    unique case (state_d)
      OWN0: begin
        grant_d = 2'b01;
        hex1_d  = bus.src0_hex1;
        hex0_d  = bus.src0_hex0;
      end
      OWN1: begin
        grant_d = 2'b10;
        hex1_d  = bus.src1_hex1;
        hex0_d  = bus.src1_hex0;
      end
      default: ;
    endcase
    if (state_d != IDLE)
      en_d = !bus.blink[own_d] || phase_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      hold_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      ptr_q   <= 1'b1;
      grant_q <= 2'b00;
      en_q    <= 1'b0;
      hex1_q  <= 4'h0;
      hex0_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      hold_q  <= hold_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      en_q    <= en_d;
      hex1_q  <= hex1_d;
      hex0_q  <= hex0_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.en7Seg = en_q;
  assign bus.hex1   = hex1_q;
  assign bus.hex0   = hex0_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed checks of arbitration, hold, blink and reset, followed
// by a random run checking exclusivity and data routing.
module tb_seg_display_arbiter;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;

  seg_display_arbiter_if bus ();

  seg_display_arbiter #(
    .CLK_PER_TICK(4),
    .MIN_HOLD    (3),
    .BLINK_TICKS (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
  endtask

  // reset lands between edges; outputs must clear before the next edge
  task automatic do_reset();
    @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    chk("rst_grant", {6'b0, bus.grant}, 8'h00);
    chk("rst_en", {7'b0, bus.en7Seg}, 8'h00);
    chk("rst_hex", {bus.hex1, bus.hex0}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  logic       e;
  logic [7:0] p0, p1, ph, xh;

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    rst   = 1'b0;
    bus.req       = 2'b00;
    bus.blink     = 2'b00;
    bus.src0_hex1 = 4'h5;
    bus.src0_hex0 = 4'hA;
    bus.src1_hex1 = 4'hC;
    bus.src1_hex0 = 4'h7;

    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_grant", {6'b0, bus.grant}, 8'h00);
      chk("idle_en", {7'b0, bus.en7Seg}, 8'h00);
    end
    chk("idle_hex", {bus.hex1, bus.hex0}, 8'h00);

    do_reset();
    bus.req = 2'b11;
    step(1);
    chk("tie_grant", {6'b0, bus.grant}, 8'h01);
    chk("tie_hex", {bus.hex1, bus.hex0}, 8'h5A);
    chk("tie_en", {7'b0, bus.en7Seg}, 8'h01);
    bus.src0_hex0 = 4'h3;
    step(1);
    chk("track_hex", {bus.hex1, bus.hex0}, 8'h53);

    step(10);
    chk("hold0_grant", {6'b0, bus.grant}, 8'h01);
    step(1);
    chk("hand1_grant", {6'b0, bus.grant}, 8'h02);
    chk("hand1_hex", {bus.hex1, bus.hex0}, 8'hC7);
    chk("hand1_en", {7'b0, bus.en7Seg}, 8'h01);
    step(11);
    chk("hold1_grant", {6'b0, bus.grant}, 8'h02);
    step(1);
    chk("rr_grant", {6'b0, bus.grant}, 8'h01);
    chk("rr_hex", {bus.hex1, bus.hex0}, 8'h53);

    bus.req = 2'b00;
    step(1);
    chk("rel_grant", {6'b0, bus.grant}, 8'h00);
    chk("rel_en", {7'b0, bus.en7Seg}, 8'h00);
    chk("rel_hex", {bus.hex1, bus.hex0}, 8'h53);
    bus.req = 2'b10;
    step(1);
    chk("one_grant", {6'b0, bus.grant}, 8'h02);
    chk("one_hex", {bus.hex1, bus.hex0}, 8'hC7);
    bus.req = 2'b01;
    step(1);
    chk("swap_grant", {6'b0, bus.grant}, 8'h01);
    chk("swap_hex", {bus.hex1, bus.hex0}, 8'h53);
    chk("swap_en", {7'b0, bus.en7Seg}, 8'h01);

    do_reset();
    bus.blink = 2'b01;
    bus.req   = 2'b01;
    for (int i = 1; i <= 25; i++) begin
      step(1);
      e = ((i / 8) % 2) == 0;
      chk("blink_en", {7'b0, bus.en7Seg}, {7'b0, e});
    end
    chk("blink_grant", {6'b0, bus.grant}, 8'h01);
    bus.blink = 2'b00;
    step(1);
    chk("unblink_en", {7'b0, bus.en7Seg}, 8'h01);
    bus.blink = 2'b01;
    step(1);
    chk("reblink_en", {7'b0, bus.en7Seg}, 8'h00);

    do_reset();
    ph = 8'h00;
    for (int i = 0; i < 10000; i++) begin
      bus.req       = 2'($urandom_range(3, 0));
      bus.blink     = 2'($urandom_range(3, 0));
      bus.src0_hex1 = 4'($urandom_range(15, 0));
      bus.src0_hex0 = 4'($urandom_range(15, 0));
      bus.src1_hex1 = 4'($urandom_range(15, 0));
      bus.src1_hex0 = 4'($urandom_range(15, 0));
      p0 = {bus.src0_hex1, bus.src0_hex0};
      p1 = {bus.src1_hex1, bus.src1_hex0};
      step(1);
      chk("no_11", {7'b0, bus.grant == 2'b11}, 8'h00);
      chk("idle_dark",
          {7'b0, (bus.grant == 2'b00) && bus.en7Seg}, 8'h00);
      xh = (bus.grant == 2'b01) ? p0 :
           (bus.grant == 2'b10) ? p1 : ph;
      chk("route_hex", {bus.hex1, bus.hex0}, xh);
      ph = xh;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
